// File: rtl/io_window_decode_if.sv
// rtl/io_window_decode_if.sv - CPU I/O bus, config bus and slot-side signals of the window decoder
interface io_window_decode_if #(
  parameter int ADDR_W    = 16,
  parameter int NUM_SLOTS = 5
);
  logic [ADDR_W-1:0]    addr;
  logic                 iorq_n;
  logic                 r_w_;
  logic                 cfg_we;
  logic [7:0]           cfg_addr;
  logic [7:0]           cfg_wdata;
  logic [7:0]           cfg_rdata;
  logic [NUM_SLOTS-1:0] dev_ready_n;
  logic [NUM_SLOTS-1:0] cs_n;
  logic                 ready_n;
  logic                 io_r_w_;
  logic                 data_oe_n;
  logic                 data_dir;
  logic                 bus_err;
  logic                 miss;
  logic                 win_valid;
  logic [3:0]           win_index;
  logic [2:0]           sel_slot;

  modport master (
    output addr, iorq_n, r_w_, cfg_we, cfg_addr, cfg_wdata, dev_ready_n,
    input  cfg_rdata, cs_n, ready_n, io_r_w_, data_oe_n, data_dir, bus_err, miss,
           win_valid, win_index, sel_slot
  );

  modport slave (
    input  addr, iorq_n, r_w_, cfg_we, cfg_addr, cfg_wdata, dev_ready_n,
    output cfg_rdata, cs_n, ready_n, io_r_w_, data_oe_n, data_dir, bus_err, miss,
           win_valid, win_index, sel_slot
  );
endinterface

// File: rtl/io_window_decode.sv
// rtl/io_window_decode.sv - I/O window decoder: base/mask windows to slot chip selects with waits and timeout
module io_window_decode #(
  parameter int         ADDR_W    = 16,
  parameter int         NUM_WIN   = 8,
  parameter int         NUM_SLOTS = 5,
  parameter logic [7:0] TO_RESET  = 8'd32
) (
  input logic clk,
  input logic rst,
  io_window_decode_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_ACTIVE, S_WAIT, S_DONE, S_MISS, S_ERR} state_t;

  logic [15:0]        win_base [NUM_WIN];
  logic [15:0]        win_mask [NUM_WIN];
  logic [NUM_WIN-1:0] win_en;
  logic [2:0]         win_slot [NUM_WIN];
  logic [1:0]         win_op   [NUM_WIN];
  logic [7:0]         win_wait [NUM_WIN];
  logic [7:0]         to_reg;
  logic               sticky_to;

  state_t     state;
  logic [7:0] wcnt;
  logic [7:0] tcnt;
  logic [7:0] cyc_to;

  logic       hit;
  logic [3:0] hit_idx;
  logic [2:0] hit_slot;
  logic [7:0] hit_wait;
  logic       tmo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < NUM_WIN; w++) begin
        win_base[w] <= '0;
        win_mask[w] <= '0;
        win_en[w]   <= 1'b0;
        win_slot[w] <= '0;
        win_op[w]   <= 2'b11;
        win_wait[w] <= '0;
      end
      to_reg <= TO_RESET;
    end else if (bus.cfg_we) begin
      for (int w = 0; w < NUM_WIN; w++) begin
        if (!bus.cfg_addr[7] && bus.cfg_addr[6:3] == 4'(w)) begin
          case (bus.cfg_addr[2:0])
            3'd0: win_base[w][7:0]  <= bus.cfg_wdata;
            3'd1: win_base[w][15:8] <= bus.cfg_wdata;
            3'd2: win_mask[w][7:0]  <= bus.cfg_wdata;
            3'd3: win_mask[w][15:8] <= bus.cfg_wdata;
            3'd4: begin
              win_en[w]   <= bus.cfg_wdata[7];
              win_slot[w] <= bus.cfg_wdata[2:0];
            end
            3'd5: win_op[w]   <= bus.cfg_wdata[1:0];
            3'd6: win_wait[w] <= bus.cfg_wdata;
            default: ;
          endcase
        end
      end
      if (bus.cfg_addr == 8'h80) to_reg <= bus.cfg_wdata;
    end
  end

  always_comb begin
    bus.cfg_rdata = 8'h00;
    for (int w = 0; w < NUM_WIN; w++) begin
      if (!bus.cfg_addr[7] && bus.cfg_addr[6:3] == 4'(w)) begin
        case (bus.cfg_addr[2:0])
          3'd0: bus.cfg_rdata = win_base[w][7:0];
          3'd1: bus.cfg_rdata = win_base[w][15:8];
          3'd2: bus.cfg_rdata = win_mask[w][7:0];
          3'd3: bus.cfg_rdata = win_mask[w][15:8];
          3'd4: bus.cfg_rdata = {win_en[w], 4'b0000, win_slot[w]};
          3'd5: bus.cfg_rdata = {6'b000000, win_op[w]};
          3'd6: bus.cfg_rdata = win_wait[w];
          default: bus.cfg_rdata = 8'h00;
        endcase
      end
    end
    if (bus.cfg_addr == 8'h80) bus.cfg_rdata = to_reg;
    if (bus.cfg_addr == 8'h81) bus.cfg_rdata = {7'b0000000, sticky_to};
  end

  // Scan from the top down so the lowest hitting window is the last one assigned.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_slot = '0;
    hit_wait = '0;
    for (int w = NUM_WIN - 1; w >= 0; w--) begin
      if (win_en[w]
          && (((bus.addr ^ win_base[w][ADDR_W-1:0]) & win_mask[w][ADDR_W-1:0]) == '0)
          && (bus.r_w_ ? win_op[w][0] : win_op[w][1])
          && (32'(win_slot[w]) < NUM_SLOTS)) begin
        hit      = 1'b1;
        hit_idx  = 4'(w);
        hit_slot = win_slot[w];
        hit_wait = win_wait[w];
      end
    end
  end

  // tcnt counts edges already spent since entry; the edge that would make it T is the timeout edge.
  assign tmo = (cyc_to != 8'd0) && (({1'b0, tcnt} + 9'd1) == {1'b0, cyc_to});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      bus.cs_n      <= '1;
      bus.ready_n   <= 1'b1;
      bus.io_r_w_   <= 1'b1;
      bus.data_oe_n <= 1'b1;
      bus.bus_err   <= 1'b0;
      bus.miss      <= 1'b0;
      bus.win_valid <= 1'b0;
      bus.win_index <= '0;
      bus.sel_slot  <= '0;
      wcnt          <= '0;
      tcnt          <= '0;
      cyc_to        <= '0;
      sticky_to     <= 1'b0;
    end else begin
      if (bus.cfg_we && bus.cfg_addr == 8'h81 && bus.cfg_wdata[0]) sticky_to <= 1'b0;
      if (state != S_IDLE && bus.iorq_n) begin
        state         <= S_IDLE;
        bus.cs_n      <= '1;
        bus.ready_n   <= 1'b1;
        bus.io_r_w_   <= 1'b1;
        bus.data_oe_n <= 1'b1;
        bus.bus_err   <= 1'b0;
        bus.miss      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (!bus.iorq_n) begin
              bus.io_r_w_   <= bus.r_w_;
              bus.win_valid <= hit;
              bus.win_index <= hit_idx;
              bus.sel_slot  <= hit_slot;
              tcnt          <= '0;
              cyc_to        <= to_reg;
              if (hit) begin
                state         <= S_ACTIVE;
                bus.cs_n      <= ~(NUM_SLOTS'(1) << hit_slot);
                bus.ready_n   <= 1'b0;
                bus.data_oe_n <= 1'b0;
                wcnt          <= hit_wait;
              end else begin
                state    <= S_MISS;
                bus.miss <= 1'b1;
              end
            end
          end
          S_ACTIVE, S_WAIT: begin
            if (tmo) begin
              state         <= S_ERR;
              bus.cs_n      <= '1;
              bus.ready_n   <= 1'b1;
              bus.data_oe_n <= 1'b1;
              bus.bus_err   <= 1'b1;
              sticky_to     <= 1'b1;
            end else begin
              tcnt <= tcnt + 8'd1;
              if (state == S_ACTIVE && wcnt != 8'd0) begin
                wcnt <= wcnt - 8'd1;
              end else if (bus.dev_ready_n[bus.sel_slot]) begin
                state       <= S_DONE;
                bus.ready_n <= 1'b1;
              end else begin
                state <= S_WAIT;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.data_dir = bus.io_r_w_;

endmodule

// File: tb/tb_io_window_decode.sv
// tb/tb_io_window_decode.sv - scoreboard bench for io_window_decode against a window-table reference model
module tb_io_window_decode;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  io_window_decode_if #(.ADDR_W(16), .NUM_SLOTS(5)) bus ();

  io_window_decode #(.ADDR_W(16), .NUM_WIN(8), .NUM_SLOTS(5), .TO_RESET(8'd32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int kind;   // 0 done, 1 miss, 2 timeout, 3 aborted
    int cs;
    int lat;
    int idx;
    int slot;
    int rw;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b1;

  int m_base [8];
  int m_mask [8];
  int m_en   [8];
  int m_slot [8];
  int m_op   [8];
  int m_wait [8];
  int m_to;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cfg_wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    bus.cfg_we    = 1'b1;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  task automatic cfg_rd_chk(input string name, input logic [7:0] a, input int exp);
    bus.cfg_addr = a;
    #1;
    chk(name, int'(bus.cfg_rdata), exp);
  endtask

  task automatic set_win(input int w, input int base, input int mask, input int en,
                         input int slot, input int op, input int wt);
    logic [7:0] a;
    a = 8'(w * 8);
    cfg_wr(a + 8'd0, 8'(base));
    cfg_wr(a + 8'd1, 8'(base >> 8));
    cfg_wr(a + 8'd2, 8'(mask));
    cfg_wr(a + 8'd3, 8'(mask >> 8));
    cfg_wr(a + 8'd4, 8'((en << 7) | slot));
    cfg_wr(a + 8'd5, 8'(op));
    cfg_wr(a + 8'd6, 8'(wt));
    m_base[w] = base & 16'hffff;
    m_mask[w] = mask & 16'hffff;
    m_en[w]   = en;
    m_slot[w] = slot;
    m_op[w]   = op & 3;
    m_wait[w] = wt;
  endtask

  task automatic set_to(input int t);
    cfg_wr(8'h80, 8'(t));
    m_to = t;
  endtask

  // Reference: first window (lowest index) whose rules all hold, else a miss.
  task automatic model(input int a, input int rw, output int found, output int idx);
    found = 0;
    idx   = 0;
    for (int w = 0; w < 8; w++) begin
      if (found == 0 && m_en[w] == 1 && ((a ^ m_base[w]) & m_mask[w]) == 0
          && ((rw == 1) ? (m_op[w] & 1) : (m_op[w] & 2)) != 0 && m_slot[w] < 5) begin
        found = 1;
        idx   = w;
      end
    end
  endtask

  task automatic run_cycle(input int a, input int rw, input int stall, input bit abort);
    exp_t e;
    int   found, idx, wt, done_edge, n;
    model(a, rw, found, idx);
    e.rw  = rw;
    e.idx = idx;
    wt    = 0;
    if (found == 1) begin
      e.slot = m_slot[idx];
      e.cs   = 31 & ~(1 << m_slot[idx]);
      wt     = m_wait[idx];
      done_edge = 1 + wt + stall;
      if (abort) begin
        e.kind = 3; e.lat = 1;
      end else if (m_to != 0 && m_to <= done_edge) begin
        e.kind = 2; e.lat = m_to;
      end else begin
        e.kind = 0; e.lat = done_edge;
      end
    end else begin
      e.kind = 1; e.cs = 31; e.lat = 0; e.slot = 0; e.idx = 0;
    end
    sbq.push_back(e);

    @(negedge clk);
    bus.addr        = 16'(a);
    bus.r_w_        = rw[0];
    bus.dev_ready_n = '0;
    bus.iorq_n      = 1'b0;
    if (found == 1 && abort) begin
      @(posedge clk);
      @(negedge clk);
      bus.iorq_n = 1'b1;
      repeat (3) @(negedge clk);
      bus.dev_ready_n = '1;
    end else begin
      repeat (wt + stall + 1) @(posedge clk);
      #1 bus.dev_ready_n = '1;
      for (n = 0; n < 60; n++) begin
        @(negedge clk);
        if (bus.ready_n) break;
      end
      if (n == 60) chk("cycle_end_timeout", 0, 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.iorq_n = 1'b1;
      repeat (2) @(negedge clk);
    end
  endtask

  int   mst = 0;
  int   mon_n;
  int   ent_cs, ent_rw, ent_idx, ent_slot, ent_valid;

  task automatic mon_compare(input int kind);
    exp_t e;
    if (sbq.size() == 0) begin
      chk("unexpected_cycle", kind, -1);
    end else begin
      e = sbq.pop_front();
      chk("kind", kind, e.kind);
      chk("cs_n_at_entry", ent_cs, e.cs);
      chk("latency", mon_n, e.lat);
      chk("io_r_w_", ent_rw, e.rw);
      chk("win_valid", ent_valid, (e.kind == 1) ? 0 : 1);
      if (e.kind != 1) begin
        chk("win_index", ent_idx, e.idx);
        chk("sel_slot", ent_slot, e.slot);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        if (mst == 0) begin
          if (!bus.ready_n || bus.miss) begin
            mon_n     = 0;
            ent_cs    = int'(bus.cs_n);
            ent_rw    = int'(bus.io_r_w_);
            ent_idx   = int'(bus.win_index);
            ent_slot  = int'(bus.sel_slot);
            ent_valid = int'(bus.win_valid);
            if (bus.miss) begin
              mon_compare(1);
              mst = 2;
            end else begin
              mst = 1;
            end
          end
        end else if (mst == 1) begin
          mon_n++;
          if (bus.bus_err) begin
            mon_compare(2);
            mst = 2;
          end else if (bus.ready_n && bus.cs_n != 5'h1f) begin
            mon_compare(0);
            mst = 2;
          end else if (bus.ready_n) begin
            mon_compare(3);
            mst = 0;
          end
        end else if (bus.ready_n && bus.cs_n == 5'h1f && !bus.miss && !bus.bus_err) begin
          mst = 0;
        end
      end
    end
  end

  int pool_base [5] = '{16'h0010, 16'h0020, 16'h0100, 16'h8000, 16'h4400};
  int pool_mask [5] = '{16'hfff0, 16'hff00, 16'h0000, 16'hffff, 16'hf000};
  int to_pool   [6] = '{0, 0, 2, 4, 6, 9};

  initial begin
    int w, a;
    for (int i = 0; i < 8; i++) begin
      m_base[i] = 0; m_mask[i] = 0; m_en[i] = 0; m_slot[i] = 0; m_op[i] = 3; m_wait[i] = 0;
    end
    m_to = 32;
    bus.addr = '0; bus.iorq_n = 1'b1; bus.r_w_ = 1'b1; bus.cfg_we = 1'b0;
    bus.cfg_addr = '0; bus.cfg_wdata = '0; bus.dev_ready_n = '1;
    repeat (3) @(negedge clk);
    chk("reset_cs_n", int'(bus.cs_n), 31);
    chk("reset_ready_n", int'(bus.ready_n), 1);
    chk("reset_io_r_w_", int'(bus.io_r_w_), 1);
    chk("reset_data_oe_n", int'(bus.data_oe_n), 1);
    chk("reset_bus_err", int'(bus.bus_err), 0);
    chk("reset_win_valid", int'(bus.win_valid), 0);
    cfg_rd_chk("reset_timeout_reg", 8'h80, 32);
    cfg_rd_chk("reset_op_reg", 8'h05, 3);
    cfg_rd_chk("unmapped_read", 8'h07, 0);
    rst = 1'b0;

    set_win(0, 16'h0010, 16'hfff0, 1, 1, 3, 0);
    set_win(1, 16'h0020, 16'hfff0, 1, 2, 3, 0);
    set_win(2, 16'h0000, 16'h0000, 1, 4, 3, 0);
    cfg_rd_chk("readback_mask_hi", 8'h03, 8'hff);
    cfg_rd_chk("readback_ctrl", 8'h0c, 8'h82);
    run_cycle(16'h0012, 1, 0, 0);
    run_cycle(16'h0023, 0, 0, 0);
    run_cycle(16'h7000, 1, 0, 0);

    set_win(1, 16'h0010, 16'hff00, 1, 2, 3, 0);
    run_cycle(16'h0012, 1, 0, 0);
    set_win(1, 16'h0020, 16'hfff0, 1, 2, 3, 0);
    set_win(0, 16'h0010, 16'hfff0, 1, 1, 1, 0);
    run_cycle(16'h0010, 0, 0, 0);
    run_cycle(16'h0010, 1, 0, 0);

    set_win(1, 16'h0020, 16'hfff0, 1, 2, 3, 3);
    run_cycle(16'h0023, 1, 0, 0);
    run_cycle(16'h0023, 1, 2, 0);

    set_to(5);
    run_cycle(16'h0012, 1, 10, 0);
    cfg_rd_chk("status_sticky", 8'h81, 1);
    chk("bus_err_after_release", int'(bus.bus_err), 0);
    cfg_wr(8'h81, 8'h01);
    cfg_rd_chk("status_cleared", 8'h81, 0);

    set_to(0);
    run_cycle(16'h0023, 1, 0, 1);

    for (int i = 0; i < 3; i++) set_win(i, 0, 0, 0, 0, 3, 0);
    run_cycle(16'h1234, 1, 0, 0);

    for (int i = 0; i < 150; i++) begin
      if (i % 10 == 0) begin
        w = int'($urandom_range(0, 7));
        set_win(w, pool_base[$urandom_range(0, 4)], pool_mask[$urandom_range(0, 4)],
                ($urandom_range(0, 3) != 0) ? 1 : 0, int'($urandom_range(0, 7)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        set_to(to_pool[$urandom_range(0, 5)]);
      end
      if ($urandom_range(0, 3) == 0) a = int'($urandom_range(0, 16'hffff));
      else a = pool_base[$urandom_range(0, 4)] ^ int'($urandom_range(0, 255));
      run_cycle(a, int'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                ($urandom_range(0, 9) == 0));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    mon_en = 1'b0;

    set_win(0, 16'h0010, 16'hfff0, 1, 1, 3, 0);
    set_to(0);
    @(negedge clk);
    bus.addr = 16'h0012; bus.r_w_ = 1'b1; bus.dev_ready_n = '0; bus.iorq_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("wait_before_reset_cs_n", int'(bus.cs_n), 5'b11101);
    chk("wait_before_reset_ready_n", int'(bus.ready_n), 0);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_cs_n", int'(bus.cs_n), 31);
    chk("async_reset_ready_n", int'(bus.ready_n), 1);
    chk("async_reset_data_oe_n", int'(bus.data_oe_n), 1);
    chk("async_reset_win_valid", int'(bus.win_valid), 0);
    cfg_rd_chk("async_reset_base", 8'h00, 0);
    cfg_rd_chk("async_reset_ctrl", 8'h04, 0);
    cfg_rd_chk("async_reset_timeout", 8'h80, 32);
    bus.iorq_n = 1'b1;
    bus.dev_ready_n = '1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
